// File: rtl/imm_rot_encoder_pkg.sv
// Shared widths and FSM state encodings for the operand-2 immediate encoder and decoder.
package imm_rot_encoder_pkg;

  localparam int ROT_W  = 4;
  localparam int IMM8_W = 8;
  localparam int SHOP_W = 12;

  typedef enum logic [1:0] {
    ST_IDLE   = 2'd0,
    ST_SEARCH = 2'd1,
    ST_DONE   = 2'd2
  } state_t;

endpackage

// File: rtl/imm_rot_encoder_rotl.sv
// Combinational rotate-left by an even amount (2*rot), used to test one candidate rotation.
module imm_rotl_even
  import imm_rot_encoder_pkg::*;
(
  input  logic [31:0]      i_data,
  input  logic [ROT_W-1:0] i_rot,
  output logic [31:0]      o_data
);

  logic [4:0]  w_shamt;
  logic [63:0] w_dbl;

  // Shifting the doubled word left keeps the wrapped-around bits in the upper half.
  assign w_shamt = {i_rot, 1'b0};
  assign w_dbl   = {i_data, i_data} << w_shamt;
  assign o_data  = w_dbl[63:32];

endmodule

// File: rtl/imm_rot_encoder.sv
// Iterative search for {rotate_imm, immed_8} such that value == ROR(immed_8, 2*rotate_imm),
// with an optional second pass on ~value for MOV->MVN rewriting.
module imm_rot_encoder
  import imm_rot_encoder_pkg::*;
#(
  parameter bit INV_EN = 1'b1
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              in_valid,
  output logic              in_ready,
  input  logic [31:0]       in_value,
  input  logic              in_allow_inv,
  output logic              out_valid,
  input  logic              out_ready,
  output logic              out_found,
  output logic              out_inv,
  output logic [SHOP_W-1:0] out_shifter_operand
);

  state_t             r_state;
  state_t             w_nextState;
  logic [31:0]        r_value;
  logic [ROT_W-1:0]   r_rot;
  logic               r_pass;
  logic               r_allow;
  logic               r_outValid;
  logic               r_found;
  logic               r_inv;
  logic [SHOP_W-1:0]  r_shop;

  logic [31:0]        w_cur;
  logic [31:0]        w_cand;
  logic               w_hit;
  logic               w_lastRot;
  logic               w_retry;
  logic               w_outFire;

  assign w_cur     = r_pass ? ~r_value : r_value;
  assign w_hit     = (w_cand[31:8] == 24'd0);
  assign w_lastRot = (r_rot == 4'd15);
  assign w_retry   = !r_pass && r_allow;
  assign w_outFire = r_outValid && out_ready;

  imm_rotl_even u_rotl (
    .i_data (w_cur),
    .i_rot  (r_rot),
    .o_data (w_cand)
  );

  always_comb begin
    w_nextState = r_state;
    case (r_state)
      ST_IDLE:   if (in_valid) w_nextState = ST_SEARCH;
      ST_SEARCH: if (w_hit || (w_lastRot && !w_retry)) w_nextState = ST_DONE;
      ST_DONE:   if (w_outFire) w_nextState = ST_IDLE;
      default:   w_nextState = ST_IDLE;
    endcase
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) r_state <= ST_IDLE;
    else     r_state <= w_nextState;
  end

  // DONE spends one cycle before out_valid rises; results are already latched by then.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_value    <= '0;
      r_rot      <= '0;
      r_pass     <= 1'b0;
      r_allow    <= 1'b0;
      r_outValid <= 1'b0;
      r_found    <= 1'b0;
      r_inv      <= 1'b0;
      r_shop     <= '0;
    end else begin
      case (r_state)
        ST_IDLE: begin
          if (in_valid) begin
            r_value <= in_value;
            r_allow <= in_allow_inv & INV_EN;
            r_rot   <= '0;
            r_pass  <= 1'b0;
          end
        end
        ST_SEARCH: begin
          if (w_hit) begin
            r_found <= 1'b1;
            r_inv   <= r_pass;
            r_shop  <= {r_rot, w_cand[7:0]};
          end else if (!w_lastRot) begin
            r_rot <= r_rot + 4'd1;
          end else if (w_retry) begin
            r_pass <= 1'b1;
            r_rot  <= '0;
          end else begin
            r_found <= 1'b0;
            r_inv   <= 1'b0;
            r_shop  <= '0;
          end
        end
        ST_DONE: r_outValid <= !w_outFire;
        default: r_outValid <= 1'b0;
      endcase
    end
  end

  assign in_ready            = (r_state == ST_IDLE);
  assign out_valid           = r_outValid;
  assign out_found           = r_found;
  assign out_inv             = r_inv;
  assign out_shifter_operand = r_shop;

endmodule

// File: tb/tb_imm_rot_encoder.sv
// Randomized self-checking bench for imm_rot_encoder against a brute-force encoding model.
module tb_imm_rot_encoder;

  logic        clk;
  logic        rst;
  logic        in_valid;
  logic        in_ready;
  logic [31:0] in_value;
  logic        in_allow_inv;
  logic        out_valid;
  logic        out_ready;
  logic        out_found;
  logic        out_inv;
  logic [11:0] out_shifter_operand;

  int checks = 0;
  int errors = 0;

  imm_rot_encoder #(.INV_EN(1'b1)) dut (
    .clk                 (clk),
    .rst                 (rst),
    .in_valid            (in_valid),
    .in_ready            (in_ready),
    .in_value            (in_value),
    .in_allow_inv        (in_allow_inv),
    .out_valid           (out_valid),
    .out_ready           (out_ready),
    .out_found           (out_found),
    .out_inv             (out_inv),
    .out_shifter_operand (out_shifter_operand)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic checkOutput(input string tag, input logic [31:0] observed, input logic [31:0] expected);
    checks++;
    if (observed !== expected) begin
      errors++;
      $display("[TB] FAIL %s: got 'h%0h, expected 'h%0h", tag, observed, expected);
    end
  endtask

  function automatic logic [31:0] rotr(input logic [31:0] x, input int n);
    logic [63:0] d;
    d = {x, x} >> (n % 32);
    return d[31:0];
  endfunction

  // Reference: try every rotation in order, then the inverted value if allowed.
  task automatic refEncode(input logic [31:0] value, input logic allow,
                           output logic found, output logic inv, output logic [11:0] shop, output int lat);
    logic [31:0] cur;
    logic [7:0]  imm;
    found = 1'b0; inv = 1'b0; shop = 12'h000;
    lat = allow ? 33 : 17;
    for (int p = 0; p < (allow ? 2 : 1); p++) begin
      cur = (p == 1) ? ~value : value;
      for (int r = 0; r < 16; r++) begin
        if (!found) begin
          imm = 8'(rotr(cur, 32 - 2 * r));
          if (rotr({24'd0, imm}, 2 * r) == cur) begin
            found = 1'b1;
            inv   = (p == 1);
            shop  = {4'(r), imm};
            lat   = 2 + 16 * p + r;
          end
        end
      end
    end
  endtask

  // Issues one request, measures latency, optionally stalls out_ready, then completes the handshake.
  task automatic applyStimulus(input string tag, input logic [31:0] value, input logic allow, input int stall);
    logic eFound, eInv;
    logic [11:0] eShop;
    int eLat, k, w;
    refEncode(value, allow, eFound, eInv, eShop, eLat);
    w = 0;
    @(negedge clk);
    while (!in_ready && w < 50) begin
      @(negedge clk);
      w++;
    end
    if (!in_ready) begin
      checkOutput({tag, "_ready_timeout"}, 32'(in_ready), 32'd1);
      return;
    end
    in_valid     = 1'b1;
    in_value     = value;
    in_allow_inv = allow;
    @(posedge clk);
    #1;
    in_valid     = 1'b0;
    in_value     = ~value;
    in_allow_inv = ~allow;
    k = 0;
    do begin
      @(posedge clk);
      k++;
      @(negedge clk);
    end while (!out_valid && k < 40);
    if (!out_valid) begin
      checkOutput({tag, "_valid_timeout"}, 32'(out_valid), 32'd1);
      return;
    end
    checkOutput({tag, "_latency"}, 32'(k), 32'(eLat));
    checkOutput({tag, "_found"}, 32'(out_found), 32'(eFound));
    checkOutput({tag, "_inv"}, 32'(out_inv), 32'(eInv));
    checkOutput({tag, "_shop"}, 32'(out_shifter_operand), 32'(eShop));
    for (int s = 0; s < stall; s++) begin
      @(negedge clk);
      checkOutput({tag, "_hold_valid"}, 32'(out_valid), 32'd1);
      checkOutput({tag, "_hold_shop"}, 32'(out_shifter_operand), 32'(eShop));
      checkOutput({tag, "_hold_inready"}, 32'(in_ready), 32'd0);
    end
    out_ready = 1'b1;
    @(negedge clk);
    out_ready = 1'b0;
    checkOutput({tag, "_post_valid"}, 32'(out_valid), 32'd0);
    checkOutput({tag, "_post_inready"}, 32'(in_ready), 32'd1);
  endtask

  function automatic logic [31:0] randValue();
    logic [31:0] v;
    case ($urandom_range(3))
      0, 1: v = rotr({24'd0, 8'($urandom)}, 2 * $urandom_range(15));
      2:    v = ~rotr({24'd0, 8'($urandom)}, 2 * $urandom_range(15));
      default: v = $urandom;
    endcase
    return v;
  endfunction

  initial begin
    int k;
    logic sawValid;
    rst = 1'b1; in_valid = 1'b0; in_value = '0; in_allow_inv = 1'b0; out_ready = 1'b0;
    repeat (2) @(negedge clk);
    checkOutput("rst_inready", 32'(in_ready), 32'd1);
    checkOutput("rst_outvalid", 32'(out_valid), 32'd0);
    checkOutput("rst_found", 32'(out_found), 32'd0);
    checkOutput("rst_inv", 32'(out_inv), 32'd0);
    checkOutput("rst_shop", 32'(out_shifter_operand), 32'd0);
    rst = 1'b0;

    applyStimulus("ff", 32'h0000_00FF, 1'b0, 0);
    applyStimulus("ff000000", 32'hFF00_0000, 1'b0, 0);
    applyStimulus("wrap", 32'hC000_003F, 1'b1, 0);
    applyStimulus("rot15", 32'h0000_03FC, 1'b0, 0);
    applyStimulus("inv", 32'hFFFF_FF00, 1'b1, 0);
    applyStimulus("noinv", 32'hFFFF_FF00, 1'b0, 0);
    applyStimulus("miss2", 32'h1234_5678, 1'b1, 0);
    applyStimulus("stall", 32'h0003_FC00, 1'b0, 5);

    // Abort a search at rot 7 with an async reset pulse.
    @(negedge clk);
    in_valid = 1'b1; in_value = 32'h1234_5678; in_allow_inv = 1'b0;
    @(posedge clk);
    #1 in_valid = 1'b0;
    repeat (7) @(posedge clk);
    #2 rst = 1'b1;
    #1;
    checkOutput("abort_inready", 32'(in_ready), 32'd1);
    checkOutput("abort_outvalid", 32'(out_valid), 32'd0);
    @(negedge clk);
    rst = 1'b0;
    sawValid = 1'b0;
    for (k = 0; k < 40; k++) begin
      @(negedge clk);
      if (out_valid) sawValid = 1'b1;
    end
    checkOutput("abort_no_result", 32'(sawValid), 32'd0);
    applyStimulus("after_abort", 32'h0000_00FF, 1'b0, 0);

    for (int i = 0; i < 1500; i++) begin
      applyStimulus("rand", randValue(), 1'($urandom), ($urandom_range(7) == 0) ? 2 : 0);
    end

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
